// File: rtl/uart_tx_fifo.sv
// UART transmitter with an integrated transmit FIFO.
// Frame: start(0), DATA_BITS data LSB first, optional parity, STOP_BITS stop(1).
// FSM state is registered one cycle ahead of the serial pin, so tx_line,
// tx_active and tx_done are all plain registers and stay mutually aligned.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 125000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tx_valid,
  input  logic [DATA_BITS-1:0]          tx_data,
  output logic                          tx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          tx_active,
  output logic                          tx_done,
  output logic                          tx_line
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = 4;  // indexes 0..8 data bits and 0..1 stop bits

  // Elaboration-time parameter legality
  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_fifo: CLK_FREQ/BAUD must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
    $error("uart_tx_fifo: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_par
    $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_sb
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         baud_q, baud_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_BITS-1:0]  data_q, data_d;
  logic [AW:0]           wptr_q, rptr_q;
  logic                  line_q, line_d;
  logic                  active_q;
  logic                  done_q, done_d;

  logic [DATA_BITS-1:0]  mem [FIFO_DEPTH];
  logic [AW:0]           count;
  logic                  full, empty, push, pop;
  logic                  baud_end, parity_bit;
  logic [DATA_BITS-1:0]  data_sh;
  logic [DATA_BITS-1:0]  head;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  assign count      = wptr_q - rptr_q;
  assign full       = (count == (AW+1)'(FIFO_DEPTH));
  assign empty      = (count == '0);
  assign push       = tx_valid && !full;
  assign head       = mem[rptr_q[AW-1:0]];
  assign baud_end   = (baud_q == CW'(CLKS_PER_BIT - 1));
  assign data_sh    = data_q >> bit_q;
  assign parity_bit = (PARITY == 1) ? ~(^data_q) : (^data_q);

  // FIFO storage; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (push) mem[wptr_q[AW-1:0]] <= tx_data;
  end

  // State, counters, pointers and the registered serial outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      data_q   <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      line_q   <= 1'b1;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      data_q   <= data_d;
      wptr_q   <= wptr_q + (AW+1)'(push);
      rptr_q   <= rptr_q + (AW+1)'(pop);
      line_q   <= line_d;
      active_q <= (state_q != S_IDLE);
      done_q   <= done_d;
    end
  end

  // Next-state, pop and line value for the current bit
  always_comb begin
    state_d = state_q;
    baud_d  = baud_end ? '0 : baud_q + CW'(1);
    bit_d   = bit_q;
    data_d  = data_q;
    pop     = 1'b0;
    done_d  = 1'b0;
    line_d  = 1'b1;
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (!empty) begin
          pop     = 1'b1;
          data_d  = head;
          state_d = S_START;
        end
      end
      S_START: begin
        line_d = 1'b0;
        if (baud_end) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        line_d = data_sh[0];
        if (baud_end) begin
          if (bit_q == BW'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      S_PARITY: begin
        line_d = parity_bit;
        if (baud_end) begin
          state_d = S_STOP;
          bit_d   = '0;
        end
      end
      S_STOP: begin
        line_d = 1'b1;
        if (baud_end) begin
          if (bit_q == BW'(STOP_BITS - 1)) begin
            // Last stop clock: finish the frame, chain straight into the next
            done_d = 1'b1;
            bit_d  = '0;
            if (!empty) begin
              pop     = 1'b1;
              data_d  = head;
              state_d = S_START;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign tx_ready   = !full;
  assign fifo_count = count;
  assign tx_active  = active_q;
  assign tx_done    = done_q;
  assign tx_line    = line_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three configurations driven from shared inputs,
// each checked every cycle against a frame-schedule model.
module tb_uart_tx_fifo;
  localparam int NI   = 3;
  localparam int MAXF = 4096;

  // inst0: 8N1 depth 4, inst1: 8O2 depth 4, inst2: 7E1 depth 16 (CPB=3, floored)
  int cpb [NI] = '{10, 10, 3};
  int db  [NI] = '{8, 8, 7};
  int par [NI] = '{0, 1, 2};
  int sb  [NI] = '{1, 2, 1};
  int dep [NI] = '{4, 4, 16};

  logic           clk, rst, tx_valid;
  logic [7:0]     tx_data;
  logic [NI-1:0]  rdy, act, done, line;
  logic [2:0]     fc0, fc1;
  logic [4:0]     fc2;

  int checks, failures, cyc;
  bit chk_en;

  // Model: every accepted word becomes a frame whose line-start edge is known
  int         fS [NI][MAXF];
  logic [7:0] fW [NI][MAXF];
  int         nf [NI];
  int         base_i [NI];
  bit         acc [NI];

  uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(rdy[0]), .fifo_count(fc0), .tx_active(act[0]), .tx_done(done[0]),
    .tx_line(line[0]));

  uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(1),
                 .STOP_BITS(2), .FIFO_DEPTH(4)) u1 (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(rdy[1]), .fifo_count(fc1), .tx_active(act[1]), .tx_done(done[1]),
    .tx_line(line[1]));

  uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD(300000), .DATA_BITS(7), .PARITY(2),
                 .STOP_BITS(1), .FIFO_DEPTH(16)) u2 (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data[6:0]),
    .tx_ready(rdy[2]), .fifo_count(fc2), .tx_active(act[2]), .tx_done(done[2]),
    .tx_line(line[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int flen(int i);
    return (1 + db[i] + ((par[i] != 0) ? 1 : 0) + sb[i]) * cpb[i];
  endfunction

  function automatic int msk(int i);
    return (1 << db[i]) - 1;
  endfunction

  // Words still in the FIFO after edge t (a frame is popped one edge before its start)
  function automatic int cnt_after(int i, int t);
    int c = 0;
    for (int j = base_i[i]; j < nf[i]; j++)
      if (fS[i][j] - 1 > t) c++;
    return c;
  endfunction

  // Expected outputs during the cycle following edge t
  function automatic void exp_at(int i, int t, output bit e_line, output bit e_act,
                                 output bit e_done);
    e_line = 1'b1; e_act = 1'b0; e_done = 1'b0;
    for (int j = base_i[i]; j < nf[i]; j++) begin
      int k, b, w;
      k = t - fS[i][j];
      if (k >= 0 && k < flen(i)) begin
        e_act = 1'b1;
        b = k / cpb[i];
        w = int'(fW[i][j]);
        if (b == 0)                          e_line = 1'b0;
        else if (b <= db[i])                 e_line = ((w >> (b - 1)) & 1) != 0;
        else if (par[i] != 0 && b == db[i] + 1)
          e_line = (par[i] == 2) ? (^fW[i][j]) : ~(^fW[i][j]);
        else                                 e_line = 1'b1;
        if (k == flen(i) - 1) e_done = 1'b1;
      end
    end
  endfunction

  task automatic chk(input string nm, input int inst, input int actv, input int expv);
    checks++;
    if (actv != expv) begin
      failures++;
      $display("FAIL %s inst=%0d cyc=%0d got=%0d exp=%0d", nm, inst, cyc, actv, expv);
    end
  endtask

  // Apply the rules of one clock edge to the model
  task automatic model_edge();
    int t;
    t = cyc;
    for (int i = 0; i < NI; i++) begin
      acc[i] = 1'b0;
      if (rst) begin
        base_i[i] = nf[i];
      end else if (tx_valid && cnt_after(i, t - 1) < dep[i] && nf[i] < MAXF) begin
        int s;
        s = t + 2;
        if (nf[i] > base_i[i] && fS[i][nf[i]-1] + flen(i) > s)
          s = fS[i][nf[i]-1] + flen(i);
        fS[i][nf[i]] = s;
        fW[i][nf[i]] = tx_data & 8'(msk(i));
        nf[i]++;
        acc[i] = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_edge();
    @(negedge clk);
  endtask

  // Per-cycle comparison of every output of every instance against the model
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        bit el, ea, ed;
        int ec, fcv;
        exp_at(i, cyc, el, ea, ed);
        ec  = cnt_after(i, cyc);
        fcv = (i == 0) ? int'(fc0) : (i == 1) ? int'(fc1) : int'(fc2);
        chk("line",   i, int'(line[i]), int'(el));
        chk("active", i, int'(act[i]),  int'(ea));
        chk("done",   i, int'(done[i]), int'(ed));
        chk("count",  i, fcv,           ec);
        chk("ready",  i, int'(rdy[i]),  (ec < dep[i]) ? 1 : 0);
      end
    end
  end

  initial begin
    int n0, d0, dt0, k, pct, m0, s0;
    int dts [8];
    checks = 0; failures = 0; cyc = 0; chk_en = 1'b0;
    for (int i = 0; i < NI; i++) begin nf[i] = 0; base_i[i] = 0; acc[i] = 1'b0; end
    rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;

    // Reset and idle
    tick();
    chk_en = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_line", 0, int'(line[0]), 1);
    chk("rst_ready", 0, int'(rdy[0]), 1);
    chk("rst_count", 0, int'(fc0), 0);
    chk("rst_active", 0, int'(act[0]), 0);
    d0 = 0;
    for (int n = 0; n < 50; n++) begin tick(); if (done != '0) d0++; end
    chk("idle_no_done", 0, d0, 0);

    // Single frame 0xA5 into all three configurations
    tx_valid = 1'b1; tx_data = 8'hA5;
    tick();
    n0 = cyc; tx_valid = 1'b0;
    d0 = 0; dt0 = 0;
    for (int n = 0; n < 130; n++) begin
      tick();
      if (done[0]) begin d0++; dt0 = cyc; end
      case (cyc - n0)
        1:   chk("a5_pre_idle", 0, int'(line[0]), 1);
        2:   begin chk("a5_start", 0, int'(line[0]), 0); chk("a5_act", 0, int'(act[0]), 1); end
        5:   chk("a5_b0_7e1", 2, int'(line[2]), 1);
        8:   chk("a5_b1_7e1", 2, int'(line[2]), 0);
        11:  chk("a5_start_end", 0, int'(line[0]), 0);
        12:  chk("a5_b0", 0, int'(line[0]), 1);
        22:  chk("a5_b1", 0, int'(line[0]), 0);
        26:  chk("a5_par_even", 2, int'(line[2]), 1);
        31:  chk("a5_done_7e1", 2, int'(done[2]), 1);
        32:  chk("a5_b2", 0, int'(line[0]), 1);
        72:  chk("a5_b6", 0, int'(line[0]), 0);
        92:  chk("a5_par_odd", 1, int'(line[1]), 1);
        101: begin chk("a5_done", 0, int'(done[0]), 1); chk("a5_stop", 0, int'(line[0]), 1); end
        102: begin chk("a5_act_fall", 0, int'(act[0]), 0); chk("a5_done_fall", 0, int'(done[0]), 0); end
        121: chk("a5_done_8o2", 1, int'(done[1]), 1);
        122: chk("a5_act_8o2", 1, int'(act[1]), 0);
        default: ;
      endcase
    end
    chk("a5_done_cnt", 0, d0, 1);
    chk("a5_done_time", 0, dt0 - n0, 101);

    // Back-to-back frames with a full FIFO: hold valid with 0x01..0x06
    tx_valid = 1'b1; tx_data = 8'h01; k = 0; n0 = -1; d0 = 0;
    for (int n = 0; n < 700; n++) begin
      tick();
      if (acc[0]) begin
        if (k == 0) n0 = cyc;
        k++;
        if (k >= 6) tx_valid = 1'b0;
        else        tx_data = 8'(k + 1);
      end
      if (done[0]) begin if (d0 < 8) dts[d0] = cyc; d0++; end
      if (n0 >= 0) begin
        case (cyc - n0)
          4:   begin chk("b2b_full_cnt", 0, int'(fc0), 4); chk("b2b_not_ready", 0, int'(rdy[0]), 0); end
          101: begin chk("b2b_refused", 0, int'(fc0), 3); chk("b2b_done1", 0, int'(done[0]), 1); end
          102: begin
            chk("b2b_6th_in", 0, int'(fc0), 4);
            chk("b2b_no_gap", 0, int'(line[0]), 0);
            chk("b2b_act_held", 0, int'(act[0]), 1);
          end
          default: ;
        endcase
      end
    end
    tx_valid = 1'b0;
    chk("b2b_done_cnt", 0, d0, 6);
    chk("b2b_first_done", 0, dts[0] - n0, 101);
    for (int m = 1; m < 6; m++) chk("b2b_spacing", 0, dts[m] - dts[m-1], 100);
    for (int n = 0; n < 300; n++) tick();

    // Push and pop on the same edge with two words queued
    tx_valid = 1'b1; tx_data = 8'h40; tick(); m0 = cyc;
    tx_data = 8'h41; tick();
    tx_data = 8'h42; tick();
    tx_valid = 1'b0;
    for (int n = 0; n < 200 && cyc < m0 + 100; n++) tick();
    tx_valid = 1'b1; tx_data = 8'h43;
    tick();
    tx_valid = 1'b0;
    chk("pushpop_cnt", 0, int'(fc0), 2);
    for (int n = 0; n < 600; n++) tick();

    // Reset during data bit 3 with two words queued, then recover
    tx_valid = 1'b1; tx_data = 8'h11; tick(); s0 = cyc + 2;
    tx_data = 8'h22; tick();
    tx_data = 8'h33; tick();
    tx_valid = 1'b0;
    chk("mid_queued", 0, int'(fc0), 2);
    for (int n = 0; n < 200 && cyc < s0 + 44; n++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_line", 0, int'(line[0]), 1);
    chk("mid_count", 0, int'(fc0), 0);
    chk("mid_act", 0, int'(act[0]), 0);
    d0 = 0;
    for (int n = 0; n < 150; n++) begin tick(); if (done[0]) d0++; end
    chk("mid_no_done", 0, d0, 0);
    tx_valid = 1'b1; tx_data = 8'h3C; tick(); n0 = cyc; tx_valid = 1'b0;
    d0 = 0; dt0 = 0;
    for (int n = 0; n < 130; n++) begin
      tick();
      if (done[0]) begin d0++; dt0 = cyc; end
      if (cyc == n0 + 22) chk("3c_b1", 0, int'(line[0]), 0);
      if (cyc == n0 + 32) chk("3c_b2", 0, int'(line[0]), 1);
    end
    chk("3c_done_cnt", 0, d0, 1);
    chk("3c_done_time", 0, dt0 - n0, 101);

    // Randomized traffic with varying load and occasional resets
    pct = 50;
    for (int n = 0; n < 4000; n++) begin
      if (n % 200 == 0) begin
        case ($urandom_range(0, 2))
          0: pct = 10;
          1: pct = 50;
          default: pct = 95;
        endcase
      end
      tx_valid = ($urandom_range(0, 99) < pct);
      tx_data  = 8'($urandom);
      rst      = ($urandom_range(0, 1499) == 0);
      tick();
    end
    rst = 1'b0; tx_valid = 1'b0;
    for (int n = 0; n < 900; n++) tick();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
